dm_wb_cache: RTL and testbench
==============================

Name: dm_wb_cache

Overview:
- Direct-mapped, write-back, write-allocate cache that answers the pipeline's word-level cache request port (proc_*). It is the responder for the processor's ICACHE_*/DCACHE_* initiator signals.
- Misses are served through the block-level slow-memory handshake (mem_*). The same module is instantiated once as the D-cache and once as the I-cache between RISCV_Pipeline and the slow memories.

Parameters:
- IDX_W, 3, index width; the cache holds 2**IDX_W lines of 4 words (128 b) each.
- TAG_W, 25, tag width; must equal 28 - IDX_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  processor read request, held until proc_stall is low.
- proc_write  in  1  processor write request, held until proc_stall is low.
- proc_addr  in  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data; valid in the cycle proc_stall is low with proc_read high.
- proc_stall  out  1  high while the current request cannot complete this cycle.
- mem_read  out  1  block read request to slow memory.
- mem_write  out  1  block write request to slow memory.
- mem_addr  out  28  block address, equal to byte address [31:4].
- mem_wdata  out  128  victim line; word 0 in [31:0], word 3 in [127:96].
- mem_rdata  in  128  refill line, same word packing as mem_wdata.
- mem_ready  in  1  one-cycle pulse from slow memory that completes the current block transfer.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[128]. Reset clears every valid, dirty, tag and data bit to 0.
- FSM states: COMPARE, WRITEBACK, ALLOCATE. Reset state is COMPARE.
- hit = valid[idx] && tag[idx] == addr tag. req = proc_read || proc_write.
- COMPARE:
  - proc_stall = req && !hit (combinational).
  - proc_rdata = data[idx] word selected by proc_addr[1:0], combinational, for any request including a miss (0 after reset).
  - Write hit: the addressed word takes proc_wdata at the clock edge and dirty[idx] is set. Zero extra latency.
  - Miss with a valid, dirty victim: go to WRITEBACK. Any other miss: go to ALLOCATE.
- WRITEBACK:
  - mem_write = 1, mem_addr = {victim tag, idx}, mem_wdata = victim line; all three held stable.
  - On mem_ready: clear dirty[idx] and go to ALLOCATE.
- ALLOCATE:
  - mem_read = 1, mem_addr = {request tag, idx}.
  - On mem_ready: data[idx] <= mem_rdata, tag updated, valid = 1, dirty = 0, go to COMPARE.
  - The request then hits in COMPARE one cycle later; proc_stall falls in that cycle.
- proc_stall = 1 for the whole time the FSM is in WRITEBACK or ALLOCATE.
- mem_read and mem_write are decoded from the state register only, so they are glitch-free and never high together. Both are 0 in COMPARE.
- mem_addr is 0 and mem_wdata is the indexed line in COMPARE (don't-care for the memory).
- Miss latency is 1 + N_wb + N_rd + 1 cycles, where N_wb and N_rd are memory response times. A clean miss has no N_wb term.
- Simultaneous proc_read and proc_write: treated as a write. proc_rdata still shows the pre-write word.
- The request must be held stable while proc_stall is high. A change of proc_addr during a stall does not abort the in-flight transfer; the new address is evaluated on return to COMPARE.
- mem_ready seen in COMPARE is ignored.
- proc_reset asserted mid-transfer: state goes to COMPARE and mem_read/mem_write drop immediately (asynchronously). All lines are invalidated; dirty data is lost by definition.
- Index wrap-around: addresses differing only in tag map to the same line and evict each other.

Decomposition:
- Package dm_wb_cache_pkg holds:
  - the state enum (COMPARE, WRITEBACK, ALLOCATE);
  - the field-slice constants for offset, index and tag;
  - the line-width constant (128).
- Sub-module cache_line_array:
  - holds the valid/dirty/tag/data arrays with asynchronous clear;
  - one combinational read port;
  - one write port that performs either a word write (with dirty set) or a full-line fill.
- The FSM and hit logic stay in dm_wb_cache.

Test Plan:
- Read miss after reset, proc_addr=30'h0000_0005, memory returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 with mem_ready 5 cycles after mem_read rises -> mem_read high with mem_addr=28'h000_0001; proc_stall falls 1 cycle after mem_ready; proc_rdata=32'h2222_2222.
- Write hit to 30'h0000_0006 with data 32'hDEAD_BEEF after the previous fill -> proc_stall stays 0; a following read of the same address returns 32'hDEAD_BEEF with no stall.
- Read of conflicting address 30'h0000_0025 (same index 1, tag 1) -> WRITEBACK first: mem_write with mem_addr=28'h000_0001 and mem_wdata word 2 = 32'hDEAD_BEEF. Then ALLOCATE: mem_read with mem_addr=28'h000_0009. mem_read and mem_write are never high together.
- Write miss to clean line 30'h0000_0010 -> no WRITEBACK; ALLOCATE, then the write completes in COMPARE; dirty[4]=1; proc_stall falls 1 cycle after mem_ready.
- proc_reset pulsed during ALLOCATE -> mem_read low in the same cycle. A subsequent read of the previously filled address misses again (valid cleared).
- proc_read and proc_write both high on a hit, wdata 32'h1234_5678 -> the word is written; a subsequent read returns 32'h1234_5678.

Source files
------------

// File: rtl/dm_wb_cache_pkg.sv
// Shared types and address-field constants for the direct-mapped write-back cache.
// The index width is a module parameter, so the tag field position is derived in the top.
package dm_wb_cache_pkg;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    localparam int ADDR_W  = 30;
    localparam int BLK_W   = 28;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 128;
    localparam int OFF_LSB = 0;
    localparam int OFF_W   = 2;
    localparam int IDX_LSB = OFF_LSB + OFF_W;

endpackage

// File: rtl/dm_wb_cache_line_array.sv
// Valid/dirty/tag/data storage for the cache: one combinational read port and one
// write port doing either a word write (sets dirty), a line fill, or a dirty clear.
module cache_line_array
    import dm_wb_cache_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              word_we,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [WORD_W-1:0] word_data,
    input  logic              fill_we,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              clean_we
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]             valid_q, valid_d;
    logic [LINES-1:0]             dirty_q, dirty_d;
    logic [LINES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [LINES-1:0][LINE_W-1:0] data_q, data_d;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_we) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = 1'b0;
            tag_d[wr_idx]   = fill_tag;
            data_d[wr_idx]  = fill_data;
        end else if (word_we) begin
            data_d[wr_idx][{word_off, 5'd0} +: WORD_W] = word_data;
            dirty_d[wr_idx] = 1'b1;
        end else if (clean_we) begin
            dirty_d[wr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back/write-allocate cache between the pipeline's word port and
// a block-level slow memory. The missing index/tag is latched so address changes mid-stall are harmless.
module dm_wb_cache
    import dm_wb_cache_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 25
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0] proc_wdata,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BLK_W-1:0]  mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int TAG_LSB = IDX_LSB + IDX_W;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req, hit, in_cmp;
    logic              word_we, fill_we, clean_we;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;

    state_e            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [BLK_W-1:0]  mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;

    assign req_off = proc_addr[OFF_LSB +: OFF_W];
    assign req_idx = proc_addr[IDX_LSB +: IDX_W];
    assign req_tag = proc_addr[TAG_LSB +: TAG_W];

    assign in_cmp   = (state_q == COMPARE);
    // Outside COMPARE the array is steered to the latched miss line so the victim stays stable.
    assign rd_idx   = in_cmp ? req_idx : miss_idx_q;
    assign req      = proc_read || proc_write;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign word_we  = in_cmp && proc_write && hit;
    assign fill_we  = (state_q == ALLOCATE) && mem_ready;
    assign clean_we = (state_q == WRITEBACK) && mem_ready;

    assign proc_stall = !in_cmp || (req && !hit);
    assign proc_rdata = rd_data[{req_off, 5'd0} +: WORD_W];
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = rd_data;

    cache_line_array #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (proc_reset),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_idx    (in_cmp ? req_idx : miss_idx_q),
        .word_we   (word_we),
        .word_off  (req_off),
        .word_data (proc_wdata),
        .fill_we   (fill_we),
        .fill_tag  (miss_tag_q),
        .fill_data (mem_rdata),
        .clean_we  (clean_we)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        case (state_q)
            COMPARE: begin
                if (req && !hit) begin
                    miss_idx_d = req_idx;
                    miss_tag_d = req_tag;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, req_idx};
                    end else begin
                        state_d    = ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {miss_tag_q, miss_idx_q};
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_d    = COMPARE;
                    mem_read_d = 1'b0;
                    mem_addr_d = '0;
                end
            end
            default: begin
                state_d     = COMPARE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= COMPARE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            miss_idx_q  <= miss_idx_d;
            miss_tag_q  <= miss_tag_d;
        end
    end

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed bench for dm_wb_cache: hand-computed vectors covering fills, write hits,
// dirty eviction, clean write miss, mid-transfer reset and simultaneous read/write.
module tb_dm_wb_cache;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    dm_wb_cache #(.IDX_W(3), .TAG_W(25)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        step(); step();
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", proc_stall); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_rw got %0b%0b want 00", mem_read, mem_write); end
        checks++; if (mem_addr !== 28'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", proc_rdata); end
        proc_reset = 1'b0;
        step();
    endtask

    task automatic test_read_miss();
        proc_read = 1'b1; proc_addr = 30'h0000_0005;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL rmiss_stall_cmp got %0b want 1", proc_stall); end
        step();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rmiss_mem_rw got %0b%0b want 10", mem_read, mem_write); end
        checks++; if (mem_addr !== 28'h000_0001) begin errors++; $display("FAIL rmiss_mem_addr got %h want 0000001", mem_addr); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (proc_stall !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL rmiss_wait_%0d stall/read got %0b%0b want 11", i, proc_stall, mem_read); end
        end
        step();
        mem_ready = 1'b1;
        mem_rdata = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL rmiss_stall_ready got %0b want 1", proc_stall); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL rmiss_stall_after got %0b want 0", proc_stall); end
        checks++; if (proc_rdata !== 32'h2222_2222) begin errors++; $display("FAIL rmiss_rdata got %h want 22222222", proc_rdata); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rmiss_read_drop got %0b want 0", mem_read); end
        proc_read = 1'b0;
        step();
    endtask

    task automatic test_write_hit();
        proc_write = 1'b1; proc_addr = 30'h0000_0006; proc_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL whit_stall got %0b want 0", proc_stall); end
        step();
        proc_write = 1'b0; proc_read = 1'b1;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL whit_rd_stall got %0b want 0", proc_stall); end
        checks++; if (proc_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL whit_rdata got %h want deadbeef", proc_rdata); end
        proc_addr = 30'h0000_0004;
        #1;
        checks++; if (proc_rdata !== 32'h1111_1111) begin errors++; $display("FAIL whit_neighbor got %h want 11111111", proc_rdata); end
        proc_read = 1'b0;
        step();
    endtask

    task automatic test_writeback();
        proc_read = 1'b1; proc_addr = 30'h0000_0025;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL wb_stall got %0b want 1", proc_stall); end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wb_mem_rw_%0d got %0b%0b want 01", i, mem_read, mem_write); end
            checks++; if (mem_addr !== 28'h000_0001) begin errors++; $display("FAIL wb_mem_addr_%0d got %h want 0000001", i, mem_addr); end
            checks++; if (mem_wdata !== 128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111) begin errors++; $display("FAIL wb_mem_wdata_%0d got %h", i, mem_wdata); end
            if (i == 0) step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL wb_alloc_rw got %0b%0b want 10", mem_read, mem_write); end
        checks++; if (mem_addr !== 28'h000_0009) begin errors++; $display("FAIL wb_alloc_addr got %h want 0000009", mem_addr); end
        step();
        mem_ready = 1'b1;
        mem_rdata = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL wb_done_stall got %0b want 0", proc_stall); end
        checks++; if (proc_rdata !== 32'hCCCC_CCCC) begin errors++; $display("FAIL wb_done_rdata got %h want cccccccc", proc_rdata); end
        proc_read = 1'b0;
        step();
    endtask

    task automatic test_write_miss_clean();
        proc_write = 1'b1; proc_addr = 30'h0000_0010; proc_wdata = 32'h5555_AAAA;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL wmiss_stall got %0b want 1", proc_stall); end
        step();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL wmiss_mem_rw got %0b%0b want 10", mem_read, mem_write); end
        checks++; if (mem_addr !== 28'h000_0004) begin errors++; $display("FAIL wmiss_mem_addr got %h want 0000004", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = '0;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL wmiss_stall_after got %0b want 0", proc_stall); end
        step();
        proc_write = 1'b0; proc_read = 1'b1;
        #1;
        checks++; if (proc_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL wmiss_rdata got %h want 5555aaaa", proc_rdata); end
        // Conflicting read must evict line 4 through WRITEBACK, proving the dirty bit was set.
        proc_addr = 30'h0000_0030;
        step();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wmiss_dirty_rw got %0b%0b want 01", mem_read, mem_write); end
        checks++; if (mem_addr !== 28'h000_0004 || mem_wdata[31:0] !== 32'h5555_AAAA) begin errors++; $display("FAIL wmiss_dirty_line got %h/%h want 0000004/5555aaaa", mem_addr, mem_wdata[31:0]); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h000_000C) begin errors++; $display("FAIL wmiss_alloc got %0b/%h want 1/000000c", mem_read, mem_addr); end
    endtask

    task automatic test_reset_mid();
        proc_reset = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_mem_rw got %0b%0b want 00", mem_read, mem_write); end
        proc_read = 1'b0;
        step();
        proc_reset = 1'b0;
        step();
        proc_read = 1'b1; proc_addr = 30'h0000_0025;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL rstmid_remiss got %0b want 1", proc_stall); end
        step();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h000_0009) begin errors++; $display("FAIL rstmid_alloc got %0b%0b/%h want 10/0000009", mem_read, mem_write, mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h6666_6666) begin errors++; $display("FAIL rstmid_refill got %0b/%h want 0/66666666", proc_stall, proc_rdata); end
    endtask

    task automatic test_rw_both();
        proc_read = 1'b1; proc_write = 1'b1; proc_addr = 30'h0000_0025; proc_wdata = 32'h1234_5678;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL rw_stall got %0b want 0", proc_stall); end
        checks++; if (proc_rdata !== 32'h6666_6666) begin errors++; $display("FAIL rw_prewrite got %h want 66666666", proc_rdata); end
        step();
        proc_write = 1'b0;
        #1;
        checks++; if (proc_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rw_after got %h want 12345678", proc_rdata); end
        proc_read = 1'b0;
        step();
    endtask

    task automatic test_ready_ignored();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rdyign_mem_rw got %0b%0b want 00", mem_read, mem_write); end
        proc_read = 1'b1;
        #1;
        checks++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdyign_hit got %0b/%h want 0/12345678", proc_stall, proc_rdata); end
        proc_read = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_write_miss_clean();
        test_reset_mid();
        test_rw_both();
        test_ready_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
